vector_accumulate_unit: RTL and testbench

//  Sits directly downstream of filterReduceUnit. Per chain, sums the reduced N-wide vectors

---
 rtl/vector_accumulate_unit_if.sv | 37 +++
 rtl/vector_accumulate_unit.sv | 101 ++++++++++
 tb/tb_vector_accumulate_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/vector_accumulate_unit_if.sv
// Vector accumulate unit bus: config stream, input vector and registered output.
// Master drives inputs; slave is the accumulate unit.
interface vector_accumulate_unit_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4
);
  localparam int CW = $clog2(MAX_CHAINS);

  logic                             tracing;
  logic                             valid_in;
  logic                             eof_in;
  logic                             bof_in;
  logic [CW-1:0]                    chainId_in;
  logic [7:0]                       configId;
  logic [7:0]                       configData;
  logic [N-1:0][DATA_WIDTH-1:0]     vector_in;
  logic [N-1:0][DATA_WIDTH-1:0]     vector_out;
  logic [CW-1:0]                    chainId_out;
  logic                             valid_out;
  logic                             eof_out;
  logic                             bof_out;

  modport master (
    output tracing, valid_in, eof_in, bof_in,
    output chainId_in, configId, configData, vector_in,
    input  vector_out, chainId_out, valid_out,
    input  eof_out, bof_out
  );

  modport slave (
    input  tracing, valid_in, eof_in, bof_in,
    input  chainId_in, configId, configData, vector_in,
    output vector_out, chainId_out, valid_out,
    output eof_out, bof_out
  );
endinterface

// File: rtl/vector_accumulate_unit.sv
// Per-chain frame accumulator: sums vectors bof..eof and emits one sum at eof.
// Chains with accumulation disabled pass through; configured while not tracing.
module vector_accumulate_unit #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4,
  parameter logic [7:0] PERSONAL_CONFIG_ID = 8'd0,
  parameter logic [0:MAX_CHAINS-1][7:0] INITIAL_FIRMWARE_ACC_EN = '0
) (
  input logic clk,
  input logic rst,
  vector_accumulate_unit_if.slave bus
);
  localparam int CW = $clog2(MAX_CHAINS);
  localparam int BW = CW + 1;
  localparam logic [BW-1:0] LAST_CNT = BW'(MAX_CHAINS);

  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

  vec_t                 r_acc [MAX_CHAINS];
  logic [MAX_CHAINS-1:0] r_started;
  logic [7:0]           r_fw [MAX_CHAINS];
  logic [BW-1:0]        r_byte_cnt;

  vec_t          r_vec_out;
  logic [CW-1:0] r_chain_out;
  logic          r_valid_out;
  logic          r_eof_out;
  logic          r_bof_out;

  logic [CW-1:0] w_c;
  logic          w_acc_mode;
  logic          w_restart;
  vec_t          w_sum;

  assign w_c        = bus.chainId_in;
  assign w_acc_mode = (r_fw[w_c] == 8'd1);
  // A fresh frame begins from zero on bof, or when nothing is pending
  assign w_restart  = bus.bof_in | ~r_started[w_c];

  always_comb begin
    w_sum = '0;
    for (int l = 0; l < N; l++) begin
      w_sum[l] = (w_restart ? '0 : r_acc[w_c][l]) + bus.vector_in[l];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < MAX_CHAINS; c++) begin
        r_acc[c] <= '0;
        r_fw[c]  <= INITIAL_FIRMWARE_ACC_EN[c];
      end
      r_started   <= '0;
      r_byte_cnt  <= '0;
      r_vec_out   <= '0;
      r_chain_out <= '0;
      r_valid_out <= 1'b0;
      r_eof_out   <= 1'b0;
      r_bof_out   <= 1'b0;
    end else if (bus.tracing) begin
      r_valid_out <= 1'b0;
      if (bus.valid_in) begin
        if (!w_acc_mode) begin
          r_vec_out   <= bus.vector_in;
          r_chain_out <= w_c;
          r_valid_out <= 1'b1;
          r_eof_out   <= bus.eof_in;
          r_bof_out   <= bus.bof_in;
        end else if (bus.eof_in) begin
          r_vec_out      <= w_sum;
          r_chain_out    <= w_c;
          r_valid_out    <= 1'b1;
          r_eof_out      <= 1'b1;
          r_bof_out      <= 1'b1;
          r_acc[w_c]     <= '0;
          r_started[w_c] <= 1'b0;
        end else begin
          r_acc[w_c]     <= w_sum;
          r_started[w_c] <= 1'b1;
        end
      end
    end else begin
      r_valid_out <= 1'b0;
      if (bus.configId == PERSONAL_CONFIG_ID) begin
        if (r_byte_cnt < LAST_CNT) begin
          r_fw[r_byte_cnt[CW-1:0]] <= bus.configData;
          r_byte_cnt <= r_byte_cnt + 1'b1;
        end
      end else begin
        r_byte_cnt <= '0;
      end
    end
  end

  assign bus.vector_out  = r_vec_out;
  assign bus.chainId_out = r_chain_out;
  assign bus.valid_out   = r_valid_out;
  assign bus.eof_out     = r_eof_out;
  assign bus.bof_out     = r_bof_out;
endmodule

// File: tb/tb_vector_accumulate_unit.sv
// Directed bench for vector_accumulate_unit.
// Hand-computed vectors cover pass, accumulate, wrap, interleave, config, reset.
module tb_vector_accumulate_unit;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int VW = N * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  vector_accumulate_unit_if #(.N(N), .DATA_WIDTH(DW), .MAX_CHAINS(4)) bus ();

  vector_accumulate_unit #(
    .N(N), .DATA_WIDTH(DW), .MAX_CHAINS(4), .PERSONAL_CONFIG_ID(8'd0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [VW-1:0] obs,
                       input logic [VW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] fill(input logic [DW-1:0] v);
    logic [VW-1:0] r;
    for (int l = 0; l < N; l++) r[l*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [VW-1:0] seq();
    logic [VW-1:0] r;
    for (int l = 0; l < N; l++) r[l*DW +: DW] = DW'(l + 1);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic b, input logic e,
                       input logic [1:0] ch, input logic [VW-1:0] vec);
    bus.valid_in   = v;
    bus.bof_in     = b;
    bus.eof_in     = e;
    bus.chainId_in = ch;
    bus.vector_in  = vec;
    tick();
    bus.valid_in = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] b0, input logic [7:0] b1,
                     input logic [7:0] b2, input logic [7:0] b3);
    bus.tracing  = 1'b0;
    bus.configId = 8'hFF;
    tick();
    bus.configId = 8'd0;
    bus.configData = b0; tick();
    bus.configData = b1; tick();
    bus.configData = b2; tick();
    bus.configData = b3; tick();
    bus.configId = 8'hFF;
    bus.tracing  = 1'b1;
  endtask

  initial begin
    bus.tracing    = 1'b1;
    bus.valid_in   = 1'b0;
    bus.bof_in     = 1'b0;
    bus.eof_in     = 1'b0;
    bus.chainId_in = '0;
    bus.configId   = 8'hFF;
    bus.configData = 8'd0;
    bus.vector_in  = '0;
    tick();
    check("rst_valid", VW'(bus.valid_out), VW'(0));
    check("rst_vec", bus.vector_out, '0);
    rst = 1'b0;
    tick();

    // pass-through with default firmware
    drive(1, 0, 0, 2, seq());
    check("pass_valid", VW'(bus.valid_out), VW'(1));
    check("pass_vec", bus.vector_out, seq());
    check("pass_chain", VW'(bus.chainId_out), VW'(2));
    tick();
    check("idle_valid", VW'(bus.valid_out), VW'(0));

    cfg(8'd1, 8'd1, 8'd1, 8'd0);

    // basic frame
    drive(1, 1, 0, 0, fill(1));
    check("acc_v0", VW'(bus.valid_out), VW'(0));
    drive(1, 0, 0, 0, fill(2));
    check("acc_v1", VW'(bus.valid_out), VW'(0));
    drive(1, 0, 1, 0, fill(3));
    check("acc_valid", VW'(bus.valid_out), VW'(1));
    check("acc_vec", bus.vector_out, fill(6));
    check("acc_flags", VW'({bus.bof_out, bus.eof_out}), VW'(2'b11));
    check("acc_chain", VW'(bus.chainId_out), VW'(0));
    drive(1, 0, 1, 0, fill(4));
    check("acc_fresh", bus.vector_out, fill(4));

    // wrap and single-vector frame
    drive(1, 1, 0, 0, fill(32'hFFFF_FFFF));
    drive(1, 0, 1, 0, fill(32'h2));
    check("wrap", bus.vector_out, fill(32'h1));
    drive(1, 1, 1, 0, fill(5));
    check("single", bus.vector_out, fill(5));

    // bof mid-frame restarts
    drive(1, 1, 0, 0, fill(7));
    drive(1, 1, 0, 0, fill(2));
    drive(1, 0, 1, 0, fill(3));
    check("rebof", bus.vector_out, fill(5));

    // interleaved chains
    drive(1, 1, 0, 0, fill(1));
    drive(1, 1, 0, 1, fill(10));
    drive(1, 0, 0, 0, fill(1));
    drive(1, 0, 0, 1, fill(10));
    drive(1, 0, 1, 0, fill(1));
    check("il_c0", bus.vector_out, fill(3));
    check("il_c0_ch", VW'(bus.chainId_out), VW'(0));
    drive(1, 0, 1, 1, fill(10));
    check("il_c1", bus.vector_out, fill(30));
    check("il_c1_ch", VW'(bus.chainId_out), VW'(1));

    // pass chain keeps its flags
    drive(1, 1, 0, 3, fill(9));
    check("pass_flags", VW'({bus.valid_out, bus.bof_out, bus.eof_out}),
          VW'(3'b110));

    // config stream: 5th byte ignored, valid_out held low
    bus.tracing  = 1'b0;
    bus.configId = 8'hFF;
    tick();
    bus.configId = 8'd0;
    bus.valid_in = 1'b1;
    bus.configData = 8'd1; tick();
    check("cfg_v0", VW'(bus.valid_out), VW'(0));
    bus.configData = 8'd0; tick();
    bus.configData = 8'd1; tick();
    bus.configData = 8'd0; tick();
    bus.configData = 8'd7; tick();
    check("cfg_v4", VW'(bus.valid_out), VW'(0));
    bus.valid_in = 1'b0;
    bus.configId = 8'hFF;
    bus.tracing  = 1'b1;

    drive(1, 1, 0, 0, fill(9));
    check("fw0_acc", VW'(bus.valid_out), VW'(0));
    drive(1, 0, 0, 1, fill(9));
    check("fw1_pass", VW'(bus.valid_out), VW'(1));
    drive(1, 1, 0, 2, fill(9));
    check("fw2_acc", VW'(bus.valid_out), VW'(0));
    drive(1, 0, 0, 3, fill(9));
    check("fw3_pass", VW'(bus.valid_out), VW'(1));
    drive(1, 0, 1, 0, fill(1));
    check("fw0_sum", bus.vector_out, fill(10));

    // reset mid-frame on chain 2 (already holds 9)
    drive(1, 0, 0, 2, fill(2));
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", VW'(bus.valid_out), VW'(0));
    check("arst_vec", bus.vector_out, '0);
    tick();
    rst = 1'b0;
    cfg(8'd0, 8'd0, 8'd1, 8'd0);
    drive(1, 0, 1, 2, fill(4));
    check("post_rst", bus.vector_out, fill(4));
    check("post_rst_v", VW'(bus.valid_out), VW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
